// File: rtl/reg_write_queue.sv
// Write-back staging FIFO feeding the register-file write decoder.
// Buffers (address, data) pairs, drains one per cycle and forwards the newest pending value to readers.
module reg_write_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wrValid,
  input  logic [ADDR_WIDTH-1:0]   wrAddr,
  input  logic [DATA_WIDTH-1:0]   wrData,
  output logic                    wrReady,
  input  logic                    stall,
  output logic [ADDR_WIDTH-1:0]   decAddr,
  output logic                    decEnable,
  output logic [DATA_WIDTH-1:0]   decData,
  input  logic [ADDR_WIDTH-1:0]   lookupAddr,
  output logic                    lookupHit,
  output logic [DATA_WIDTH-1:0]   lookupData,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] r_addrMem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dataMem [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_lookupHit;
  logic [DATA_WIDTH-1:0] w_lookupData;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full queue refuses pushes even when the head drains this cycle.
  assign wrReady   = !w_full && !reset;
  assign w_push    = wrValid && wrReady;
  assign w_pop     = !w_empty && !stall;
  assign decEnable = w_pop;

  assign decAddr = w_empty ? '0 : r_addrMem[r_head];
  assign decData = w_empty ? '0 : r_dataMem[r_head];

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

  // Pointers are power-of-two wide, so natural overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addrMem[r_tail] <= wrAddr;
      r_dataMem[r_tail] <= wrData;
    end
  end

  // Walk from head towards tail so the newest matching entry overrides older ones.
  always_comb begin
    w_lookupHit  = 1'b0;
    w_lookupData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) &&
          (r_addrMem[r_head + PTR_W'(i)] == lookupAddr)) begin
        w_lookupHit  = 1'b1;
        w_lookupData = r_dataMem[r_head + PTR_W'(i)];
      end
    end
  end

  assign lookupHit  = w_lookupHit;
  assign lookupData = w_lookupData;

endmodule

// File: tb/tb_reg_write_queue.sv
// Scoreboard bench for reg_write_queue: a queue-based model predicts every output,
// a negedge monitor compares and retires drained entries.
module tb_reg_write_queue;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          wrValid;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic          wrReady;
  logic          stall;
  logic [AW-1:0] decAddr;
  logic          decEnable;
  logic [DW-1:0] decData;
  logic [AW-1:0] lookupAddr;
  logic          lookupHit;
  logic [DW-1:0] lookupData;
  logic [2:0]    count;
  logic          full;
  logic          empty;

  reg_write_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wrValid(wrValid), .wrAddr(wrAddr), .wrData(wrData), .wrReady(wrReady),
    .stall(stall),
    .decAddr(decAddr), .decEnable(decEnable), .decData(decData),
    .lookupAddr(lookupAddr), .lookupHit(lookupHit), .lookupData(lookupData),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the pending entries in order, oldest first.
  logic [AW+DW-1:0] expQ [$];
  logic             checking = 1'b0;
  logic             pushNow  = 1'b0;
  int               checks   = 0;
  int               errors   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic st, input logic [AW-1:0] la);
    @(posedge clk);
    #1;
    reset      = rst;
    wrValid    = v;
    wrAddr     = a;
    wrData     = d;
    stall      = st;
    lookupAddr = la;
    @(negedge clk);
  endtask

  // Monitor: predict all outputs from the model, compare, then retire a drained entry.
  always @(negedge clk) begin
    if (checking) begin
      int               n;
      logic             expReady;
      logic             expEn;
      logic             expHit;
      logic [DW-1:0]    expLData;
      n        = expQ.size();
      expReady = (n < DEPTH) && !reset;
      expEn    = (n != 0) && !stall;
      expHit   = 1'b0;
      expLData = '0;
      for (int k = n - 1; k >= 0; k--) begin
        if (expQ[k][AW+DW-1:DW] == lookupAddr) begin
          expHit   = 1'b1;
          expLData = expQ[k][DW-1:0];
          break;
        end
      end
      checkOutput("wrReady", 32'(wrReady), 32'(expReady));
      checkOutput("decEnable", 32'(decEnable), 32'(expEn));
      checkOutput("count", 32'(count), 32'(n));
      checkOutput("full", 32'(full), 32'(n == DEPTH));
      checkOutput("empty", 32'(empty), 32'(n == 0));
      checkOutput("lookupHit", 32'(lookupHit), 32'(expHit));
      checkOutput("lookupData", 32'(lookupData), 32'(expLData));
      if (n != 0) begin
        checkOutput("decAddr", 32'(decAddr), 32'(expQ[0][AW+DW-1:DW]));
        checkOutput("decData", 32'(decData), 32'(expQ[0][DW-1:0]));
      end else begin
        checkOutput("decAddrIdle", 32'(decAddr), 32'd0);
        checkOutput("decDataIdle", 32'(decData), 32'd0);
      end
      if (expEn) begin
        void'(expQ.pop_front());
      end
      pushNow = wrValid && expReady;
    end
  end

  // Model update at the clock edge: reset discards, accepted pushes join the tail.
  always @(posedge clk) begin
    if (reset) begin
      expQ.delete();
    end else if (pushNow) begin
      expQ.push_back({wrAddr, wrData});
    end
    pushNow = 1'b0;
  end

  initial begin
    reset = 1'b1; wrValid = 1'b0; wrAddr = '0; wrData = '0; stall = 1'b0; lookupAddr = '0;

    applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    checking = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);

    // Reset state and single push latency.
    applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    checkOutput("rstWrReady", 32'(wrReady), 32'd1);
    checkOutput("rstEmpty", 32'(empty), 32'd1);
    checkOutput("rstCount", 32'(count), 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd3, 16'h00AA, 1'b0, 5'd3);
    applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd3);
    checkOutput("t1DecEnable", 32'(decEnable), 32'd1);
    checkOutput("t1DecAddr", 32'(decAddr), 32'd3);
    checkOutput("t1DecData", 32'(decData), 32'h00AA);
    applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    checkOutput("t1EmptyAfter", 32'(empty), 32'd1);

    // Fill under stall, fifth offer refused, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b1, 5'(10 + i), 16'(16'h1000 + i), 1'b1, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd9, 16'hDEAD, 1'b1, 5'd0);
    checkOutput("t2Full", 32'(full), 32'd1);
    checkOutput("t2WrReady", 32'(wrReady), 32'd0);
    checkOutput("t2Count", 32'(count), 32'd4);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
      checkOutput("t2DrainAddr", 32'(decAddr), 32'(10 + i));
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    checkOutput("t2Empty", 32'(empty), 32'd1);

    // Full with simultaneous drain: push refused, accepted next cycle, order across wrap.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b1, 5'(20 + i), 16'(16'h2000 + i), 1'b1, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd21, 16'h3333, 1'b0, 5'd0);
    checkOutput("t3WrReadyFull", 32'(wrReady), 32'd0);
    checkOutput("t3DecEnable", 32'(decEnable), 32'd1);
    applyStimulus(1'b0, 1'b1, 5'd21, 16'h3333, 1'b1, 5'd0);
    checkOutput("t3Count3", 32'(count), 32'd3);
    checkOutput("t3WrReady", 32'(wrReady), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd21);
    checkOutput("t3Count4", 32'(count), 32'd4);
    checkOutput("t3LookupData", 32'(lookupData), 32'h3333);
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    checkOutput("t3Empty", 32'(empty), 32'd1);

    // Forwarding: newest duplicate wins, miss returns zero.
    applyStimulus(1'b0, 1'b1, 5'd7, 16'h1111, 1'b1, 5'd7);
    applyStimulus(1'b0, 1'b1, 5'd7, 16'h2222, 1'b1, 5'd7);
    checkOutput("t4OlderHit", 32'(lookupData), 32'h1111);
    applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd7);
    checkOutput("t4Hit", 32'(lookupHit), 32'd1);
    checkOutput("t4Data", 32'(lookupData), 32'h2222);
    applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd8);
    checkOutput("t4Miss", 32'(lookupHit), 32'd0);
    checkOutput("t4MissData", 32'(lookupData), 32'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd7);

    // Reset with pending entries discards them.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 5'(i + 1), 16'(16'h5000 + i), 1'b1, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 16'h0, 1'b1, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd1);
    checkOutput("t5Count", 32'(count), 32'd0);
    checkOutput("t5Empty", 32'(empty), 32'd1);
    checkOutput("t5DecEnable", 32'(decEnable), 32'd0);
    checkOutput("t5Lookup", 32'(lookupHit), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(1'b0, ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)),
                    16'($urandom), ($urandom_range(0, 99) < 35), 5'($urandom_range(0, 7)));
      if (count > 3'(DEPTH)) checkOutput("countRange", 32'(count), 32'(DEPTH));
    end
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    checkOutput("finalEmpty", 32'(empty), 32'd1);

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
